// File: rtl/io_bus_arbiter_pkg.sv
// io_bus_arbiter_pkg: shared IO bus widths, access-size codes and owner FSM encodings.
package io_bus_arbiter_pkg;
    localparam int IO_ADDR_W = 32;
    localparam int IO_DATA_W = 32;
    localparam int IO_CTRL_W = 3;
    localparam int CNT_W     = 4;
    localparam logic [IO_CTRL_W-1:0] CTRL_BYTE = 3'd0;
    localparam logic [IO_CTRL_W-1:0] CTRL_HALF = 3'd1;
    localparam logic [IO_CTRL_W-1:0] CTRL_WORD = 3'd2;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_OWN0 = 2'd1;
    localparam logic [1:0] ST_OWN1 = 2'd2;
endpackage

// File: rtl/io_bus_arbiter_starve_counter.sv
// starve_counter: saturating count of consecutive denied m1 cycles, cleared whenever m1 is not waiting.
module starve_counter
    import io_bus_arbiter_pkg::*;
#(
    parameter int LIM = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic inc_i,
    output logic hit_o
);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    always_comb cnt_d = !inc_i ? '0 : (&cnt_q ? cnt_q : cnt_q + 1'b1);
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
    assign hit_o = cnt_q == CNT_W'(LIM);
endmodule

// File: rtl/io_bus_arbiter.sv
// io_bus_arbiter: two-master single-cycle IO bus arbiter, m0 priority with m1 anti-starvation,
// and a one-cycle read-return router.
module io_bus_arbiter
    import io_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W     = IO_ADDR_W,
    parameter int DATA_W     = IO_DATA_W,
    parameter int CTRL_W     = IO_CTRL_W,
    parameter int STARVE_LIM = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [CTRL_W-1:0] m0_ctrl,
    input  logic [DATA_W-1:0] m0_wd,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rd,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [CTRL_W-1:0] m1_ctrl,
    input  logic [DATA_W-1:0] m1_wd,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rd,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [CTRL_W-1:0] bus_ctrl,
    output logic [DATA_W-1:0] bus_wd,
    output logic              bus_we,
    input  logic [DATA_W-1:0] bus_rd
);
    logic       starve;
    logic       rd_pend_q, rd_pend_d;
    logic [1:0] state_q, state_d;
    logic       ret;

    starve_counter #(.LIM(STARVE_LIM)) u_starve (
        .clk  (clk),
        .rst  (rst_n),
        .inc_i(m1_req & ~m1_gnt),
        .hit_o(starve)
    );

    // rst_n is active-high here: reset masks grants in the same cycle.
    assign m0_gnt = ~rst_n & m0_req & ~(starve & m1_req);
    assign m1_gnt = ~rst_n & m1_req & (starve | ~m0_req);

    assign bus_addr = m0_gnt ? m0_addr : m1_gnt ? m1_addr : '0;
    assign bus_ctrl = m0_gnt ? m0_ctrl : m1_gnt ? m1_ctrl : '0;
    assign bus_wd   = m0_gnt ? m0_wd   : m1_gnt ? m1_wd   : '0;
    assign bus_we   = m0_gnt ? m0_we   : m1_gnt & m1_we;

    always_comb begin
        state_d   = m0_gnt ? ST_OWN0 : m1_gnt ? ST_OWN1 : ST_IDLE;
        rd_pend_d = (m0_gnt | m1_gnt) & ~bus_we;
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q   <= ST_IDLE;
            rd_pend_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rd_pend_q <= rd_pend_d;
        end
    end

    // A read issued just before reset must not return while reset is held.
    assign ret       = rd_pend_q & ~rst_n;
    assign m0_rvalid = ret & (state_q == ST_OWN0);
    assign m1_rvalid = ret & (state_q == ST_OWN1);
    assign m0_rd     = m0_rvalid ? bus_rd : '0;
    assign m1_rd     = m1_rvalid ? bus_rd : '0;
endmodule

// File: tb/tb_io_bus_arbiter.sv
// tb_io_bus_arbiter: directed scenario checks for io_bus_arbiter with STARVE_LIM=4.
module tb_io_bus_arbiter;
    import io_bus_arbiter_pkg::*;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr, m0_wd, m1_addr, m1_wd;
    logic [2:0]  m0_ctrl, m1_ctrl;
    logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
    logic [31:0] m0_rd, m1_rd;
    logic [31:0] bus_addr, bus_wd, bus_rd;
    logic [2:0]  bus_ctrl;
    logic        bus_we;
    int          pass_cnt = 0;
    int          tot_cnt = 0;

    always #5 clk = ~clk;

    io_bus_arbiter #(.STARVE_LIM(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_ctrl(m0_ctrl), .m0_wd(m0_wd),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rd(m0_rd),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_ctrl(m1_ctrl), .m1_wd(m1_wd),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rd(m1_rd),
        .bus_addr(bus_addr), .bus_ctrl(bus_ctrl), .bus_wd(bus_wd), .bus_we(bus_we), .bus_rd(bus_rd)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        m0_req = 0; m0_we = 0; m0_addr = 0; m0_ctrl = 0; m0_wd = 0;
        m1_req = 0; m1_we = 0; m1_addr = 0; m1_ctrl = 0; m1_wd = 0;
        bus_rd = 0;
        cyc();
    endtask

    task automatic test_reset();
        rst_n = 1; m0_req = 1; m0_addr = 32'h44; m1_req = 1; m1_addr = 32'h88; m0_we = 1; m0_wd = 32'h9;
        #4;
        tot_cnt++; if ({m0_gnt, m1_gnt} !== 2'b00) $display("FAIL reset_gnt: got %b exp 00", {m0_gnt, m1_gnt}); else pass_cnt++;
        tot_cnt++; if ({bus_addr, bus_wd, bus_ctrl, bus_we} !== '0) $display("FAIL reset_bus: got %h/%h/%h/%b exp 0", bus_addr, bus_wd, bus_ctrl, bus_we); else pass_cnt++;
        tot_cnt++; if ({m0_rvalid, m1_rvalid} !== 2'b00) $display("FAIL reset_rvalid: got %b exp 00", {m0_rvalid, m1_rvalid}); else pass_cnt++;
        cyc();
        rst_n = 0;
        idle();
    endtask

    task automatic test_single_read();
        m0_req = 1; m0_we = 0; m0_addr = 32'h100; m0_ctrl = CTRL_WORD;
        #4;
        tot_cnt++; if ({m0_gnt, m1_gnt} !== 2'b10) $display("FAIL rd_gnt: got %b exp 10", {m0_gnt, m1_gnt}); else pass_cnt++;
        tot_cnt++; if (bus_addr !== 32'h100 || bus_ctrl !== CTRL_WORD || bus_we !== 1'b0) $display("FAIL rd_bus: got %h/%h/%b exp 100/2/0", bus_addr, bus_ctrl, bus_we); else pass_cnt++;
        cyc();
        m0_req = 0; bus_rd = 32'hDEADBEEF;
        #4;
        tot_cnt++; if (m0_rvalid !== 1'b1 || m0_rd !== 32'hDEADBEEF) $display("FAIL rd_ret: got %b/%h exp 1/deadbeef", m0_rvalid, m0_rd); else pass_cnt++;
        tot_cnt++; if (m1_rvalid !== 1'b0 || m1_rd !== 32'h0) $display("FAIL rd_other: got %b/%h exp 0/0", m1_rvalid, m1_rd); else pass_cnt++;
        tot_cnt++; if (bus_addr !== 32'h0) $display("FAIL rd_idle_bus: got %h exp 0", bus_addr); else pass_cnt++;
        cyc();
        #4;
        tot_cnt++; if (m0_rvalid !== 1'b0 || m0_rd !== 32'h0) $display("FAIL rd_once: got %b/%h exp 0/0", m0_rvalid, m0_rd); else pass_cnt++;
        idle();
    endtask

    task automatic test_starve();
        logic exp1;
        m0_req = 1; m0_addr = 32'h0; m1_req = 1; m1_addr = 32'h200;
        for (int c = 0; c < 10; c++) begin
            exp1 = (c == 4) || (c == 9);
            bus_rd = 32'h1000 + c;
            #4;
            tot_cnt++; if ({m0_gnt, m1_gnt} !== {~exp1, exp1}) $display("FAIL starve_c%0d: got %b exp %b", c, {m0_gnt, m1_gnt}, {~exp1, exp1}); else pass_cnt++;
            if (c == 4) begin
                tot_cnt++; if (bus_addr !== 32'h200) $display("FAIL starve_addr: got %h exp 200", bus_addr); else pass_cnt++;
            end
            if (c == 5) begin
                tot_cnt++; if (m1_rvalid !== 1'b1 || m1_rd !== 32'h1005 || m0_rvalid !== 1'b0) $display("FAIL starve_ret: got %b/%h/%b exp 1/1005/0", m1_rvalid, m1_rd, m0_rvalid); else pass_cnt++;
            end
            cyc();
        end
        idle();
    endtask

    task automatic test_back_to_back();
        m0_req = 1; m0_addr = 32'h10;
        #4;
        tot_cnt++; if (m0_gnt !== 1'b1) $display("FAIL b2b_g0: got %b exp 1", m0_gnt); else pass_cnt++;
        cyc();
        m0_req = 0; m1_req = 1; m1_addr = 32'h20; bus_rd = 32'h11;
        #4;
        tot_cnt++; if (m1_gnt !== 1'b1 || bus_addr !== 32'h20) $display("FAIL b2b_g1: got %b/%h exp 1/20", m1_gnt, bus_addr); else pass_cnt++;
        tot_cnt++; if (m0_rvalid !== 1'b1 || m0_rd !== 32'h11 || m1_rvalid !== 1'b0) $display("FAIL b2b_r0: got %b/%h/%b exp 1/11/0", m0_rvalid, m0_rd, m1_rvalid); else pass_cnt++;
        cyc();
        m1_req = 0; bus_rd = 32'h22;
        #4;
        tot_cnt++; if (m1_rvalid !== 1'b1 || m1_rd !== 32'h22 || m0_rvalid !== 1'b0 || m0_rd !== 32'h0) $display("FAIL b2b_r1: got %b/%h/%b/%h exp 1/22/0/0", m1_rvalid, m1_rd, m0_rvalid, m0_rd); else pass_cnt++;
        cyc();
        #4;
        tot_cnt++; if ({m0_rvalid, m1_rvalid} !== 2'b00) $display("FAIL b2b_end: got %b exp 00", {m0_rvalid, m1_rvalid}); else pass_cnt++;
        idle();
    endtask

    task automatic test_write();
        m1_req = 1; m1_we = 1; m1_addr = 32'h300; m1_wd = 32'h55; m1_ctrl = CTRL_BYTE;
        #4;
        tot_cnt++; if (m1_gnt !== 1'b1 || bus_we !== 1'b1 || bus_wd !== 32'h55 || bus_addr !== 32'h300) $display("FAIL wr_bus: got %b/%b/%h/%h exp 1/1/55/300", m1_gnt, bus_we, bus_wd, bus_addr); else pass_cnt++;
        cyc();
        m1_req = 0; m1_we = 0; bus_rd = 32'h77;
        #4;
        tot_cnt++; if ({m0_rvalid, m1_rvalid, bus_we} !== 3'b000 || bus_wd !== 32'h0) $display("FAIL wr_after: got %b/%h exp 000/0", {m0_rvalid, m1_rvalid, bus_we}, bus_wd); else pass_cnt++;
        idle();
    endtask

    task automatic test_reset_mid_read();
        m0_req = 1; m0_addr = 32'h40;
        #4;
        tot_cnt++; if (m0_gnt !== 1'b1) $display("FAIL rstrd_g: got %b exp 1", m0_gnt); else pass_cnt++;
        cyc();
        rst_n = 1; m1_req = 1; m1_addr = 32'h50; bus_rd = 32'hAA;
        #4;
        tot_cnt++; if (m0_rvalid !== 1'b0 || m0_rd !== 32'h0) $display("FAIL rstrd_rv: got %b/%h exp 0/0", m0_rvalid, m0_rd); else pass_cnt++;
        tot_cnt++; if ({m0_gnt, m1_gnt} !== 2'b00 || bus_addr !== 32'h0) $display("FAIL rstrd_gnt: got %b/%h exp 00/0", {m0_gnt, m1_gnt}, bus_addr); else pass_cnt++;
        cyc();
        rst_n = 0; m0_req = 0;
        #4;
        tot_cnt++; if ({m0_rvalid, m1_rvalid} !== 2'b00) $display("FAIL rstrd_post: got %b exp 00", {m0_rvalid, m1_rvalid}); else pass_cnt++;
        tot_cnt++; if (m1_gnt !== 1'b1 || bus_addr !== 32'h50) $display("FAIL rstrd_first: got %b/%h exp 1/50", m1_gnt, bus_addr); else pass_cnt++;
        idle();
    endtask

    task automatic test_req_drop();
        m0_req = 1; m0_addr = 32'h4; m1_req = 1; m1_addr = 32'h8;
        for (int c = 0; c < 3; c++) begin
            #4;
            tot_cnt++; if (m1_gnt !== 1'b0) $display("FAIL drop_pre%0d: got %b exp 0", c, m1_gnt); else pass_cnt++;
            cyc();
        end
        m1_req = 0;
        cyc();
        m1_req = 1;
        for (int c = 0; c < 5; c++) begin
            #4;
            tot_cnt++; if ({m0_gnt, m1_gnt} !== ((c == 4) ? 2'b01 : 2'b10)) $display("FAIL drop_post%0d: got %b exp %b", c, {m0_gnt, m1_gnt}, (c == 4) ? 2'b01 : 2'b10); else pass_cnt++;
            cyc();
        end
        idle();
    endtask

    initial begin
        rst_n = 1;
        m0_req = 0; m0_we = 0; m0_addr = 0; m0_ctrl = 0; m0_wd = 0;
        m1_req = 0; m1_we = 0; m1_addr = 0; m1_ctrl = 0; m1_wd = 0;
        bus_rd = 0;
        cyc();
        test_reset();
        test_single_read();
        test_starve();
        test_back_to_back();
        test_write();
        test_reset_mid_read();
        test_req_drop();
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end
endmodule
